// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

    localparam int FETCH_CNT_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_LATCH = 3'd3,
        ST_EXEC  = 3'd4,
        ST_INC   = 3'd5,
        ST_JUMP  = 3'd6,
        ST_FAULT = 3'd7
    } fetch_state_e;

endpackage

// File: rtl/fetch_timeout.sv
// Watchdog for the memory wait phase: counts consecutive cycles with en=1
// and flags the cycle in which the count reaches TIMEOUT_CYCLES.
module fetch_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // cnt_q holds the number of earlier consecutive enabled cycles.
    assign expired = en && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (!en) begin
            cnt_d = '0;
        end else if (!expired) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch/execute sequencer driving the PC, memory read and IR strobes.
// Optional WAIT watchdog enabled by defining FETCH_CTRL_TIMEOUT_EN.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   halt,
    input  logic                   mem_ack,
    input  logic                   exec_done,
    input  logic                   jmp,
    output logic                   pc_oe_a,
    output logic                   pc_oe_b,
    output logic                   pc_ld,
    output logic                   pc_cnt,
    output logic                   pc_rst,
    output logic                   mem_rd,
    output logic                   ir_ld,
    output logic                   exec_go,
    output logic                   busy,
    output logic                   fault,
    output logic [FETCH_CNT_W-1:0] fetch_cnt,
    output fetch_state_e           state_dbg
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("fetch_ctrl: TIMEOUT_CYCLES must be at least 1");
    end

    fetch_state_e           state_q;
    fetch_state_e           state_d;
    logic [FETCH_CNT_W-1:0] fetch_cnt_q;
    logic [FETCH_CNT_W-1:0] fetch_cnt_d;
    logic                   wd_expired;

`ifdef FETCH_CTRL_TIMEOUT_EN
    fetch_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .en     (state_q == ST_WAIT),
        .expired(wd_expired)
    );
`else
    assign wd_expired = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_ADDR;
            ST_ADDR:  state_d = ST_WAIT;
            ST_WAIT: begin
                // A late acknowledge still wins over the watchdog.
                if (mem_ack) begin
                    state_d = ST_LATCH;
                end else if (wd_expired) begin
                    state_d = ST_FAULT;
                end
            end
            ST_LATCH: state_d = ST_EXEC;
            ST_EXEC:  if (exec_done) state_d = jmp ? ST_JUMP : ST_INC;
            ST_INC,
            ST_JUMP:  state_d = halt ? ST_IDLE : ST_ADDR;
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pc_oe_a = 1'b0;
        pc_oe_b = 1'b0;
        pc_ld   = 1'b0;
        pc_cnt  = 1'b0;
        mem_rd  = 1'b0;
        ir_ld   = 1'b0;
        exec_go = 1'b0;
        busy    = 1'b1;
        fault   = 1'b0;
        case (state_q)
            ST_IDLE: busy = 1'b0;
            ST_ADDR,
            ST_WAIT: begin
                pc_oe_a = 1'b1;
                mem_rd  = 1'b1;
            end
            ST_LATCH: ir_ld   = 1'b1;
            ST_EXEC:  exec_go = 1'b1;
            ST_INC:   pc_cnt  = 1'b1;
            ST_JUMP:  pc_ld   = 1'b1;
            ST_FAULT: begin
                busy = 1'b0;
`ifdef FETCH_CTRL_TIMEOUT_EN
                fault = 1'b1;
`endif
            end
            default: busy = 1'b0;
        endcase
    end

    assign fetch_cnt_d = (state_q == ST_LATCH) ? fetch_cnt_q + 1'b1 : fetch_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            fetch_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

    // PC register clears on the same edge as the controller.
    assign pc_rst    = rst;
    assign fetch_cnt = fetch_cnt_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: vector table, directed corner sequences and a
// randomized run against a phase-level reference model.
module tb_fetch_ctrl;
    import fetch_pkg::*;

    localparam int TO = 16;
`ifdef FETCH_CTRL_TIMEOUT_EN
    localparam bit TIMEOUT_ON = 1'b1;
`else
    localparam bit TIMEOUT_ON = 1'b0;
`endif

    // output vector: {pc_oe_a, pc_oe_b, pc_ld, pc_cnt, pc_rst, mem_rd, ir_ld, exec_go, busy, fault}
    localparam logic [9:0] O_IDLE  = 10'b0000000000;
    localparam logic [9:0] O_RST   = 10'b0000100000;
    localparam logic [9:0] O_ADDR  = 10'b1000010010;
    localparam logic [9:0] O_LATCH = 10'b0000001010;
    localparam logic [9:0] O_EXEC  = 10'b0000000110;
    localparam logic [9:0] O_INC   = 10'b0001000010;
    localparam logic [9:0] O_JUMP  = 10'b0010000010;
    localparam logic [9:0] O_FAULT = 10'b0000000001;

    logic clk = 1'b0;
    logic rst, start, halt, mem_ack, exec_done, jmp;
    logic pc_oe_a, pc_oe_b, pc_ld, pc_cnt, pc_rst, mem_rd, ir_ld, exec_go, busy, fault;
    logic [15:0] fetch_cnt;
    fetch_state_e state_dbg;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .halt(halt), .mem_ack(mem_ack),
        .exec_done(exec_done), .jmp(jmp), .pc_oe_a(pc_oe_a), .pc_oe_b(pc_oe_b),
        .pc_ld(pc_ld), .pc_cnt(pc_cnt), .pc_rst(pc_rst), .mem_rd(mem_rd),
        .ir_ld(ir_ld), .exec_go(exec_go), .busy(busy), .fault(fault),
        .fetch_cnt(fetch_cnt), .state_dbg(state_dbg)
    );

    function automatic logic [9:0] dut_out();
        return {pc_oe_a, pc_oe_b, pc_ld, pc_cnt, pc_rst, mem_rd, ir_ld, exec_go, busy, fault};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic h, input logic a, input logic d, input logic j);
        start = s; halt = h; mem_ack = a; exec_done = d; jmp = j;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0);
        rst = 1'b1;
        tick();
        tick();
        check("reset_outputs", 32'(dut_out()), 32'(O_RST));
        rst = 1'b0;
        #1;
    endtask

    typedef struct {
        logic s, h, a, d, j;
        logic [9:0]  eo;
        logic [15:0] fc;
    } vec_t;
    vec_t vecs[17];

    task automatic set_vec(input int i, input logic s, input logic h, input logic a,
                           input logic d, input logic j, input logic [9:0] eo, input logic [15:0] fc);
        vecs[i].s = s; vecs[i].h = h; vecs[i].a = a; vecs[i].d = d; vecs[i].j = j;
        vecs[i].eo = eo; vecs[i].fc = fc;
    endtask

    // Phase-level reference: where the controller should be after each edge.
    localparam int P_IDLE = 0, P_ADDR = 1, P_WAIT = 2, P_LATCH = 3,
                   P_EXEC = 4, P_INC = 5, P_JUMP = 6, P_FAULT = 7;
    int ph;
    int unsigned m_fetches;
    int m_wait;

    function automatic logic [9:0] model_out(input int p, input logic r);
        logic [9:0] o;
        case (p)
            P_ADDR, P_WAIT: o = O_ADDR;
            P_LATCH: o = O_LATCH;
            P_EXEC:  o = O_EXEC;
            P_INC:   o = O_INC;
            P_JUMP:  o = O_JUMP;
            P_FAULT: o = O_FAULT;
            default: o = O_IDLE;
        endcase
        o[5] = r;
        return o;
    endfunction

    task automatic model_step();
        if (rst) begin
            ph = P_IDLE; m_fetches = 0; m_wait = 0;
        end else begin
            case (ph)
                P_IDLE:  if (start) ph = P_ADDR;
                P_ADDR:  begin ph = P_WAIT; m_wait = 0; end
                P_WAIT: begin
                    m_wait++;
                    if (mem_ack) ph = P_LATCH;
                    else if (TIMEOUT_ON && m_wait >= TO) ph = P_FAULT;
                end
                P_LATCH: begin m_fetches = (m_fetches + 1) % 65536; ph = P_EXEC; end
                P_EXEC:  if (exec_done) ph = jmp ? P_JUMP : P_INC;
                P_INC, P_JUMP: ph = halt ? P_IDLE : P_ADDR;
                default: ph = ph;
            endcase
        end
    endtask

    initial begin
        int pulses, rd_cnt, oe_cnt, ir_cnt;
        rst = 1'b1;
        drive(0, 0, 0, 0, 0);

        // vector table: one cycle per record, checked after the edge
        set_vec(0,  0, 0, 0, 0, 0, O_IDLE,  16'd0);
        set_vec(1,  1, 0, 0, 0, 0, O_ADDR,  16'd0);
        set_vec(2,  1, 0, 1, 0, 0, O_ADDR,  16'd0);
        set_vec(3,  0, 0, 0, 0, 0, O_ADDR,  16'd0);
        set_vec(4,  0, 0, 0, 1, 0, O_ADDR,  16'd0);
        set_vec(5,  0, 0, 1, 0, 0, O_LATCH, 16'd0);
        set_vec(6,  0, 0, 0, 1, 0, O_EXEC,  16'd1);
        set_vec(7,  0, 0, 0, 0, 0, O_EXEC,  16'd1);
        set_vec(8,  0, 0, 0, 1, 1, O_JUMP,  16'd1);
        set_vec(9,  0, 0, 0, 0, 0, O_ADDR,  16'd1);
        set_vec(10, 0, 0, 1, 0, 0, O_ADDR,  16'd1);
        set_vec(11, 0, 0, 1, 0, 0, O_LATCH, 16'd1);
        set_vec(12, 0, 1, 0, 0, 0, O_EXEC,  16'd2);
        set_vec(13, 0, 1, 0, 1, 0, O_INC,   16'd2);
        set_vec(14, 0, 1, 0, 0, 0, O_IDLE,  16'd2);
        set_vec(15, 0, 0, 1, 1, 0, O_IDLE,  16'd2);
        set_vec(16, 1, 0, 0, 0, 0, O_ADDR,  16'd2);

        do_reset();
        check("reset_fetch_cnt", 32'(fetch_cnt), 32'd0);
        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].s, vecs[i].h, vecs[i].a, vecs[i].d, vecs[i].j);
            tick();
            check($sformatf("vec%0d_out", i), 32'(dut_out()), 32'(vecs[i].eo));
            check($sformatf("vec%0d_cnt", i), 32'(fetch_cnt), 32'(vecs[i].fc));
        end

        // back-to-back instructions: pc_cnt every 5 cycles
        do_reset();
        drive(1, 0, 1, 1, 0);
        tick();
        start = 1'b0;
        pulses = 0;
        for (int cyc = 2; cyc <= 15; cyc++) begin
            tick();
            if (pc_cnt) begin
                pulses++;
                check("pc_cnt_period", 32'(cyc), 32'(pulses * 5));
            end
        end
        check("pc_cnt_pulses", 32'(pulses), 32'd3);
        check("three_fetches", 32'(fetch_cnt), 32'd3);

        // acknowledge arrives in the fourth WAIT cycle
        do_reset();
        drive(1, 0, 0, 0, 0);
        tick();
        start = 1'b0;
        rd_cnt = int'(mem_rd); oe_cnt = int'(pc_oe_a); ir_cnt = int'(ir_ld);
        for (int k = 2; k <= 14; k++) begin
            mem_ack = (k == 6);
            tick();
            rd_cnt += int'(mem_rd); oe_cnt += int'(pc_oe_a); ir_cnt += int'(ir_ld);
        end
        check("slow_ack_mem_rd", 32'(rd_cnt), 32'd5);
        check("slow_ack_pc_oe_a", 32'(oe_cnt), 32'd5);
        check("slow_ack_ir_ld", 32'(ir_cnt), 32'd1);

        // fetch counter wrap, then reset in the middle of WAIT
        do_reset();
        dut.fetch_cnt_q = 16'hFFFF;
        drive(1, 0, 1, 1, 0);
        tick();
        start = 1'b0;
        tick();
        tick();
        check("wrap_before", 32'(fetch_cnt), 32'hFFFF);
        tick();
        check("wrap_after", 32'(fetch_cnt), 32'd0);
        mem_ack = 1'b0;
        tick();
        tick();
        tick();
        check("mid_wait_out", 32'(dut_out()), 32'(O_ADDR));
        rst = 1'b1;
        #1;
        check("pc_rst_follows_rst", 32'(pc_rst), 32'd1);
        tick();
        check("mid_wait_reset", 32'(dut_out()), 32'(O_RST));
        check("mid_wait_reset_cnt", 32'(fetch_cnt), 32'd0);
        rst = 1'b0;
        #1;

        // stalled memory: watchdog fault or indefinite wait
        do_reset();
        drive(1, 0, 0, 0, 0);
        tick();
        start = 1'b0;
        for (int i = 1; i <= TO; i++) tick();
        check("wait_16_no_fault", 32'(dut_out()), 32'(O_ADDR));
        tick();
        if (TIMEOUT_ON) begin
            check("timeout_fault", 32'(dut_out()), 32'(O_FAULT));
            drive(1, 0, 1, 1, 0);
            tick();
            tick();
            check("fault_sticky", 32'(dut_out()), 32'(O_FAULT));
            rst = 1'b1;
            tick();
            rst = 1'b0;
            drive(0, 0, 0, 0, 0);
            #1;
            check("fault_cleared", 32'(dut_out()), 32'(O_IDLE));
            check("fault_cleared_cnt", 32'(fetch_cnt), 32'd0);
        end else begin
            for (int i = 0; i < 30; i++) tick();
            check("wait_forever", 32'(dut_out()), 32'(O_ADDR));
        end

        // randomized run against the reference model
        do_reset();
        ph = P_IDLE; m_fetches = 0; m_wait = 0;
        for (int i = 0; i < 3000; i++) begin
            drive(1'($urandom_range(0, 99) < 30), 1'($urandom_range(0, 99) < 20),
                  1'($urandom_range(0, 99) < 40), 1'($urandom_range(0, 99) < 40),
                  1'($urandom_range(0, 1)));
            rst = ($urandom_range(0, 199) == 0);
            model_step();
            tick();
            check($sformatf("rand%0d_out", i), 32'(dut_out()), 32'(model_out(ph, rst)));
            check($sformatf("rand%0d_cnt", i), 32'(fetch_cnt), m_fetches);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
